// File: rtl/impulse_window_ctrl.sv
// -----------------------------------------------------------------------------
// impulse_window_ctrl
//   Measurement sequencer for the impulse-meter datapath. The raw sensor line
//   is synchronised and its rising edges are counted inside a gate window of
//   WINDOW_CYCLES clocks. The saturated total is converted to four BCD digits
//   by a one-iteration-per-cycle shift-add-3 engine and then published to the
//   7-segment display stage.
//
// Ports
//   clock         system clock
//   reset         asynchronous, active-low reset
//   enable        run request; held high = continuous back-to-back windows
//   sensor        raw asynchronous impulse line
//   busy          high while a window is counting, converting or publishing
//   count         last published edge count (saturated at 9999)
//   bcd3..bcd0    last published count as thousands/hundreds/tens/units
//   overflow      last published window saturated
//   result_valid  one-cycle strobe, coincident with new count/bcd/overflow
//
// Handshake: enable is a level request sampled every clock (no ready/ack).
// result_valid is a single-cycle qualifier with no back-pressure; it is high
// for exactly the one cycle in which the freshly loaded outputs first appear.
// -----------------------------------------------------------------------------
module impulse_window_ctrl #(
    parameter int WINDOW_CYCLES = 50000000,
    parameter int CNT_W         = 14
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             sensor,
    output logic             busy,
    output logic [CNT_W-1:0] count,
    output logic [3:0]       bcd3,
    output logic [3:0]       bcd2,
    output logic [3:0]       bcd1,
    output logic [3:0]       bcd0,
    output logic             overflow,
    output logic             result_valid
);

    localparam int WIN_W  = $clog2(WINDOW_CYCLES);
    localparam int CONV_W = $clog2(CNT_W + 1);
    localparam int SH_W   = 16 + CNT_W;

    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [CONV_W-1:0] CONV_LAST = CONV_W'(CNT_W - 1);
    localparam logic [CNT_W-1:0]  SAT       = CNT_W'(9999);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COUNT   = 2'd1,
        CONVERT = 2'd2,
        PUBLISH = 2'd3
    } state_t;

    state_t            state;
    logic              sync1;
    logic              sync2;
    logic              hist;
    logic              edge_hit;
    logic [WIN_W-1:0]  win_cnt;
    logic [CNT_W-1:0]  acc;
    logic [CNT_W-1:0]  acc_next;
    logic              ovf;
    logic              ovf_next;
    logic [CONV_W-1:0] conv_cnt;
    // Double-dabble register: BCD digits in the top 16 bits, binary below.
    logic [SH_W-1:0]   shreg;
    logic [SH_W-1:0]   shreg_adj;
    logic [SH_W-1:0]   shreg_next;

    // Two-flop synchroniser plus history flop for rising-edge detection.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            hist  <= 1'b0;
        end else begin
            sync1 <= sensor;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    assign edge_hit = sync2 & ~hist;

    // Accumulator update for the current COUNT cycle. An edge arriving while
    // already at 9999 is not lost silently: it marks the window as overflowed.
    always_comb begin
        acc_next = acc;
        ovf_next = ovf;
        if (edge_hit) begin
            if (acc == SAT) begin
                ovf_next = 1'b1;
            end else begin
                acc_next = acc + 1'b1;
            end
        end
    end

    // One shift-add-3 iteration: correct every BCD nibble >= 5, then shift.
    always_comb begin
        shreg_adj = shreg;
        for (int i = 0; i < 4; i++) begin
            if (shreg_adj[CNT_W + 4*i +: 4] >= 4'd5) begin
                shreg_adj[CNT_W + 4*i +: 4] = shreg_adj[CNT_W + 4*i +: 4] + 4'd3;
            end
        end
        shreg_next = {shreg_adj[SH_W-2:0], 1'b0};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            busy         <= 1'b0;
            win_cnt      <= '0;
            acc          <= '0;
            ovf          <= 1'b0;
            conv_cnt     <= '0;
            shreg        <= '0;
            count        <= '0;
            bcd3         <= 4'd0;
            bcd2         <= 4'd0;
            bcd1         <= 4'd0;
            bcd0         <= 4'd0;
            overflow     <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        state   <= COUNT;
                        busy    <= 1'b1;
                        win_cnt <= '0;
                        acc     <= '0;
                        ovf     <= 1'b0;
                    end
                end
                COUNT: begin
                    if (!enable) begin
                        // Abort: the partial window is discarded, outputs hold.
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        acc     <= acc_next;
                        ovf     <= ovf_next;
                        win_cnt <= win_cnt + 1'b1;
                        if (win_cnt == WIN_LAST) begin
                            // Load from acc_next so an edge on the last
                            // window cycle is included in the conversion.
                            state    <= CONVERT;
                            shreg    <= {16'd0, acc_next};
                            conv_cnt <= '0;
                        end
                    end
                end
                CONVERT: begin
                    shreg    <= shreg_next;
                    conv_cnt <= conv_cnt + 1'b1;
                    if (conv_cnt == CONV_LAST) begin
                        state <= PUBLISH;
                    end
                end
                PUBLISH: begin
                    count        <= acc;
                    {bcd3, bcd2, bcd1, bcd0} <= shreg[SH_W-1:CNT_W];
                    overflow     <= ovf;
                    result_valid <= 1'b1;
                    if (enable) begin
                        state   <= COUNT;
                        win_cnt <= '0;
                        acc     <= '0;
                        ovf     <= 1'b0;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
